bit_count_sequencer: RTL



---
 rtl/bit_count_sequencer_pkg.sv | 22 ++
 rtl/bit_count_sequencer_run_tracker.sv | 41 ++++
 rtl/bit_count_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bit_count_sequencer_pkg.sv
// Shared types and constants for the bit-statistics sequencer.
// Holds the FSM encoding, mode codes and digit sizing used by the top and the run trackers.
package bit_count_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_COUNT = 1'b0;
    localparam logic MODE_RUN   = 1'b1;

    localparam int DIGIT_W       = 4;
    localparam int DEFAULT_WIDTH = 6;

    // Bits needed to hold any count from 0 up to width inclusive.
    function automatic int count_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_count_sequencer_run_tracker.sv
// Tracks the current and longest run of ones on bit_in while en is high.
// max_run already includes the bit presented this cycle, so the owner can capture a final result on the same edge.
module run_tracker
    import bit_count_sequencer_pkg::*;
#(
    parameter int CNT_W = count_w(DEFAULT_WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_in,
    output logic [CNT_W-1:0] max_run
);

    logic [CNT_W-1:0] cur_q;
    logic [CNT_W-1:0] max_q;
    logic [CNT_W-1:0] cur_nxt;
    logic [CNT_W-1:0] max_nxt;

    always_comb begin
        cur_nxt = '0;
        if (bit_in) begin
            cur_nxt = cur_q + CNT_W'(1);
        end
        max_nxt = (cur_nxt > max_q) ? cur_nxt : max_q;
    end

    assign max_run = en ? max_nxt : max_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cur_q <= '0;
            max_q <= '0;
        end else if (en) begin
            cur_q <= cur_nxt;
            max_q <= max_nxt;
        end
    end

endmodule

// File: rtl/bit_count_sequencer.sv
// Multi-cycle bit statistics of an operand, shown on six display digits.
// Start/busy/done handshake; digits only change on the cycle done is high.
//
//   state | meaning
//   IDLE  | waiting for start; digits hold the previous result
//   SHIFT | one operand bit per cycle, LSB first, busy high
//   DONE  | digits freshly loaded, done high for this single cycle
module bit_count_sequencer
    import bit_count_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   operandX,
    input  logic               mode,
    output logic               busy,
    output logic               done,
    output logic [DIGIT_W-1:0] d1,
    output logic [DIGIT_W-1:0] d2,
    output logic [DIGIT_W-1:0] d3,
    output logic [DIGIT_W-1:0] d4,
    output logic [DIGIT_W-1:0] d5,
    output logic [DIGIT_W-1:0] d6
);

    localparam int CNT_W = count_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic             mode_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] zeros_q;
    logic [CNT_W-1:0] ones_nxt;
    logic [CNT_W-1:0] zeros_nxt;
    logic [CNT_W-1:0] ones_run;
    logic [CNT_W-1:0] zeros_run;
    logic             lsb;
    logic             lsb_zero;
    logic             clear;
    logic             en;

    assign lsb       = shift_q[0];
    assign lsb_zero  = ~shift_q[0];
    assign clear     = (state_q == IDLE) && start;
    assign en        = (state_q == SHIFT);
    assign ones_nxt  = ones_q + CNT_W'(lsb);
    assign zeros_nxt = zeros_q + CNT_W'(lsb_zero);

    run_tracker #(.CNT_W(CNT_W)) u_ones_run (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .en      (en),
        .bit_in  (lsb),
        .max_run (ones_run)
    );

    run_tracker #(.CNT_W(CNT_W)) u_zeros_run (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .en      (en),
        .bit_in  (lsb_zero),
        .max_run (zeros_run)
    );

    assign d1 = '0;
    assign d2 = '0;
    assign d4 = '0;
    assign d5 = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            mode_q    <= MODE_COUNT;
            bit_cnt_q <= '0;
            ones_q    <= '0;
            zeros_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            d3        <= '0;
            d6        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shift_q   <= operandX;
                        mode_q    <= mode;
                        bit_cnt_q <= LAST_IDX;
                        ones_q    <= '0;
                        zeros_q   <= '0;
                        busy      <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_q <= shift_q >> 1;
                    ones_q  <= ones_nxt;
                    zeros_q <= zeros_nxt;
                    if (bit_cnt_q == '0) begin
                        // Last bit: load digits from the totals that include it.
                        if (mode_q == MODE_RUN) begin
                            d3 <= DIGIT_W'(ones_run);
                            d6 <= DIGIT_W'(zeros_run);
                        end else begin
                            d3 <= DIGIT_W'(ones_nxt);
                            d6 <= DIGIT_W'(zeros_nxt);
                        end
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
